// File: rtl/ddr4_mon_pkg.sv
// Shared types and constants for the DDR4 command-bus monitor.
// Command codes follow the RAS/CAS/WE encoding; ACT takes the code left free by NOP.
package ddr4_mon_pkg;

    typedef enum logic [2:0] {
        CMD_MRS = 3'd0,
        CMD_REF = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RFU = 3'd3,
        CMD_WR  = 3'd4,
        CMD_RD  = 3'd5,
        CMD_ZQC = 3'd6,
        CMD_ACT = 3'd7
    } cmd_e;

    // RAS/CAS/WE values on adr[16:14] when act_n is high
    localparam logic [2:0] RCW_MRS = 3'b000;
    localparam logic [2:0] RCW_REF = 3'b001;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_RFU = 3'b011;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_ZQC = 3'b110;
    localparam logic [2:0] RCW_NOP = 3'b111;

    localparam int ERR_RW_IDLE  = 0;
    localparam int ERR_ACT_OPEN = 1;
    localparam int ERR_TRCD     = 2;
    localparam int ERR_TRP      = 3;
    localparam int ERR_REF_OPEN = 4;
    localparam int ERR_RFU      = 5;
    localparam int ERR_W        = 6;

    localparam int NUM_BANKS = 8;
    localparam int ROW_W     = 17;
    localparam int TMR_W     = 8;

    typedef struct packed {
        logic             open;
        logic [ROW_W-1:0] row;
        logic [TMR_W-1:0] rcd_cnt;
        logic [TMR_W-1:0] rp_cnt;
    } bank_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_mon_bank.sv
// One DDR4 bank: open/idle state, open row and saturating tRCD/tRP timers.
// Emits the per-command error bits that depend on this bank's state.
module ddr4_mon_bank
    import ddr4_mon_pkg::*;
#(
    parameter int T_RCD = 16,
    parameter int T_RP  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cmd_e              cmd,
    input  logic              hit,
    input  logic              prea,
    input  logic              auto_pre,
    input  logic [ROW_W-1:0]  row,
    output logic              open,
    output logic [ERR_W-1:0]  err
);

    localparam logic [TMR_W-1:0] SAT     = TMR_W'(max_int(T_RCD, T_RP));
    localparam logic [TMR_W:0]   RCD_LIM = (TMR_W+1)'(T_RCD);
    localparam logic [TMR_W:0]   RP_LIM  = (TMR_W+1)'(T_RP);

    bank_state_t state_d, state_q;
    logic [TMR_W:0] rcd_k, rp_k;

    // A timer reading n at a command edge means the reference event was n+1 edges ago.
    always_comb begin
        state_d = state_q;
        err     = '0;
        rcd_k   = {1'b0, state_q.rcd_cnt} + (TMR_W+1)'(1);
        rp_k    = {1'b0, state_q.rp_cnt} + (TMR_W+1)'(1);

        if (state_q.rcd_cnt != SAT) state_d.rcd_cnt = state_q.rcd_cnt + TMR_W'(1);
        if (state_q.rp_cnt != SAT)  state_d.rp_cnt  = state_q.rp_cnt + TMR_W'(1);

        if (prea) begin
            state_d.open   = 1'b0;
            state_d.rp_cnt = '0;
        end else if (hit) begin
            case (cmd)
                CMD_ACT: begin
                    if (state_q.open) err[ERR_ACT_OPEN] = 1'b1;
                    if (rp_k < RP_LIM) err[ERR_TRP] = 1'b1;
                    state_d.open    = 1'b1;
                    state_d.row     = row;
                    state_d.rcd_cnt = '0;
                end
                CMD_RD, CMD_WR: begin
                    if (!state_q.open)        err[ERR_RW_IDLE] = 1'b1;
                    else if (rcd_k < RCD_LIM) err[ERR_TRCD]    = 1'b1;
                    if (auto_pre) begin
                        state_d.open   = 1'b0;
                        state_d.rp_cnt = '0;
                    end
                end
                CMD_PRE: begin
                    state_d.open   = 1'b0;
                    state_d.rp_cnt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '{open: 1'b0, row: '0, rcd_cnt: SAT, rp_cnt: SAT};
        end else begin
            state_q <= state_d;
        end
    end

    assign open = state_q.open;

endmodule

// File: rtl/ddr4_cmd_monitor.sv
// Passive DDR4 command-bus monitor: decode, per-bank timing checks, sticky flags, counters.
// Define DDR4_MON_PRINT_EN for simulation messages (plus MODEL_DEBUG_CMDS for every command).
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int T_RCD = 16,
    parameter int T_RP  = 16,
    parameter int CNT_W = 32
) (
    input  logic                  c0_ddr4_ck_t,
    input  logic                  c0_ddr4_reset_n,
    input  logic                  c0_ddr4_act_n,
    input  logic [16:0]           c0_ddr4_adr,
    input  logic [1:0]            c0_ddr4_ba,
    input  logic                  c0_ddr4_bg,
    input  logic                  c0_ddr4_cke,
    input  logic                  c0_ddr4_cs_n,
    input  logic                  mon_clr,
    output logic                  mon_cmd_valid,
    output logic [2:0]            mon_cmd,
    output logic [2:0]            mon_bank,
    output logic [7:0]            mon_open_mask,
    output logic [5:0]            mon_err_flags,
    output logic [15:0]           mon_err_cnt,
    output logic [CNT_W-1:0]      mon_act_cnt,
    output logic [CNT_W-1:0]      mon_rd_cnt,
    output logic [CNT_W-1:0]      mon_wr_cnt,
    output logic                  mon_first_err_valid,
    output logic [2:0]            mon_first_err_cmd,
    output logic [2:0]            mon_first_err_bank
);

    logic       dec_valid;
    cmd_e       dec_cmd;
    logic [2:0] dec_bank;
    logic       dec_prea;

    // RCW_NOP with act_n high is the only pattern that is not reported as a command
    always_comb begin
        dec_valid = 1'b0;
        dec_cmd   = CMD_MRS;
        dec_bank  = {c0_ddr4_bg, c0_ddr4_ba};
        if (!c0_ddr4_cs_n && c0_ddr4_cke) begin
            dec_valid = 1'b1;
            if (!c0_ddr4_act_n) begin
                dec_cmd = CMD_ACT;
            end else begin
                case (c0_ddr4_adr[16:14])
                    RCW_MRS: dec_cmd = CMD_MRS;
                    RCW_REF: dec_cmd = CMD_REF;
                    RCW_PRE: dec_cmd = CMD_PRE;
                    RCW_RFU: dec_cmd = CMD_RFU;
                    RCW_WR:  dec_cmd = CMD_WR;
                    RCW_RD:  dec_cmd = CMD_RD;
                    RCW_ZQC: dec_cmd = CMD_ZQC;
                    default: dec_valid = 1'b0;
                endcase
            end
        end
        dec_prea = dec_valid && (dec_cmd == CMD_PRE) && c0_ddr4_adr[10];
    end

    logic [NUM_BANKS-1:0] bank_open;
    logic [ERR_W-1:0]     bank_err [NUM_BANKS];

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        ddr4_mon_bank #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk      (c0_ddr4_ck_t),
            .rst_n    (c0_ddr4_reset_n),
            .cmd      (dec_cmd),
            .hit      (dec_valid && (dec_bank == 3'(i))),
            .prea     (dec_prea),
            .auto_pre (c0_ddr4_adr[10]),
            .row      (c0_ddr4_adr),
            .open     (bank_open[i]),
            .err      (bank_err[i])
        );
    end

    logic             cmd_valid_d, cmd_valid_q;
    logic [2:0]       cmd_d, cmd_q, bank_d, bank_q;
    logic [5:0]       err_flags_d, err_flags_q, err_now;
    logic [15:0]      err_cnt_d, err_cnt_q;
    logic [CNT_W-1:0] act_cnt_d, act_cnt_q, rd_cnt_d, rd_cnt_q, wr_cnt_d, wr_cnt_q;
    logic             fe_valid_d, fe_valid_q;
    logic [2:0]       fe_cmd_d, fe_cmd_q, fe_bank_d, fe_bank_q;

    // Clear is applied first so that a same-cycle error or command survives it
    always_comb begin
        err_now = '0;
        for (int i = 0; i < NUM_BANKS; i++) err_now = err_now | bank_err[i];
        if (dec_valid && (dec_cmd == CMD_REF) && (|bank_open)) err_now[ERR_REF_OPEN] = 1'b1;
        if (dec_valid && (dec_cmd == CMD_RFU)) err_now[ERR_RFU] = 1'b1;

        cmd_valid_d = dec_valid;
        cmd_d       = dec_valid ? dec_cmd : cmd_q;
        bank_d      = dec_valid ? dec_bank : bank_q;

        err_flags_d = (mon_clr ? 6'd0 : err_flags_q) | err_now;
        err_cnt_d   = mon_clr ? 16'd0 : err_cnt_q;
        if ((|err_now) && (err_cnt_d != 16'hFFFF)) err_cnt_d = err_cnt_d + 16'd1;

        act_cnt_d = mon_clr ? '0 : act_cnt_q;
        rd_cnt_d  = mon_clr ? '0 : rd_cnt_q;
        wr_cnt_d  = mon_clr ? '0 : wr_cnt_q;
        if (dec_valid && (dec_cmd == CMD_ACT)) act_cnt_d = act_cnt_d + CNT_W'(1);
        if (dec_valid && (dec_cmd == CMD_RD))  rd_cnt_d  = rd_cnt_d + CNT_W'(1);
        if (dec_valid && (dec_cmd == CMD_WR))  wr_cnt_d  = wr_cnt_d + CNT_W'(1);

        fe_valid_d = mon_clr ? 1'b0 : fe_valid_q;
        fe_cmd_d   = mon_clr ? 3'd0 : fe_cmd_q;
        fe_bank_d  = mon_clr ? 3'd0 : fe_bank_q;
        if ((|err_now) && !fe_valid_d) begin
            fe_valid_d = 1'b1;
            fe_cmd_d   = dec_cmd;
            fe_bank_d  = dec_bank;
        end
    end

    always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
        if (!c0_ddr4_reset_n) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            bank_q      <= '0;
            err_flags_q <= '0;
            err_cnt_q   <= '0;
            act_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            fe_valid_q  <= 1'b0;
            fe_cmd_q    <= '0;
            fe_bank_q   <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            bank_q      <= bank_d;
            err_flags_q <= err_flags_d;
            err_cnt_q   <= err_cnt_d;
            act_cnt_q   <= act_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            fe_valid_q  <= fe_valid_d;
            fe_cmd_q    <= fe_cmd_d;
            fe_bank_q   <= fe_bank_d;
        end
    end

    assign mon_cmd_valid       = cmd_valid_q;
    assign mon_cmd             = cmd_q;
    assign mon_bank            = bank_q;
    assign mon_open_mask       = bank_open;
    assign mon_err_flags       = err_flags_q;
    assign mon_err_cnt         = err_cnt_q;
    assign mon_act_cnt         = act_cnt_q;
    assign mon_rd_cnt          = rd_cnt_q;
    assign mon_wr_cnt          = wr_cnt_q;
    assign mon_first_err_valid = fe_valid_q;
    assign mon_first_err_cmd   = fe_cmd_q;
    assign mon_first_err_bank  = fe_bank_q;

`ifdef DDR4_MON_PRINT_EN
    always @(posedge c0_ddr4_ck_t) begin
        if (c0_ddr4_reset_n && dec_valid) begin
            if (|err_now)
                $error("ddr4_cmd_monitor t=%0t cmd=%s bank=%0d row/col=0x%05h err=%06b",
                       $time, dec_cmd.name(), dec_bank, c0_ddr4_adr, err_now);
`ifdef MODEL_DEBUG_CMDS
            $display("ddr4_cmd_monitor t=%0t cmd=%s bank=%0d adr=0x%05h",
                     $time, dec_cmd.name(), dec_bank, c0_ddr4_adr);
`endif
        end
    end
`else
    // Silent build: no simulation messages.
`endif

endmodule
